// File: rtl/rhd_spi_sequencer.sv
// SPI master and frame scheduler for one RHD2000 headstage: CONVERT sweep plus three
// auxiliary commands, DDR result capture, and pipeline-aware slot tagging of results.
module rhd_spi_sequencer #(
  parameter int NUM_CHANNELS   = 32,
  parameter int CS_HIGH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [47:0] aux_cmd,
  output logic        CS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        data_valid,
  output logic [15:0] data_a,
  output logic [15:0] data_b,
  output logic [5:0]  data_slot,
  output logic        sweep_done,
  output logic        busy
);

  localparam int FRAMES = NUM_CHANNELS + 3;
  localparam int CW     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [6:0]    slot;
  logic [6:0]    tag;
  logic [1:0]    supp;
  logic [47:0]   aux_q;
  logic [15:0]   sh_a, sh_b;
  logic [15:0]   cmd;
  logic          frame_end, gap_end, last_slot, start_sweep;

  assign frame_end   = (state == FRAME) && (cnt == CW'(67));
  assign gap_end     = (state == GAP) && (cnt == CW'(CS_HIGH_CYCLES - 1));
  assign last_slot   = (slot == 7'(FRAMES - 1));
  assign start_sweep = ((state == IDLE) && enable) || (gap_end && last_slot && enable);

  // Results lag their command by two frames in the headstage pipeline.
  assign tag = (slot >= 7'd2) ? (slot - 7'd2) : (slot + 7'(FRAMES - 2));

  always_comb begin
    cmd = 16'h0000;
    if (slot < 7'(NUM_CHANNELS))
      cmd = {2'b00, slot[5:0], 8'h00};
    else if (slot == 7'(NUM_CHANNELS))
      cmd = aux_q[47:32];
    else if (slot == 7'(NUM_CHANNELS + 1))
      cmd = aux_q[31:16];
    else
      cmd = aux_q[15:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = FRAME;
      FRAME:   if (frame_end) state_nx = GAP;
      GAP:     if (gap_end) state_nx = (!last_slot || enable) ? FRAME : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign CS   = (state != FRAME);
  assign busy = (state != IDLE);
  assign SCLK = (state == FRAME) && (cnt < CW'(64)) && cnt[1];
  assign MOSI = (state == FRAME) && (cnt < CW'(64)) && cmd[4'd15 - cnt[5:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      slot       <= '0;
      supp       <= 2'd2;
      aux_q      <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      data_valid <= 1'b0;
      data_a     <= '0;
      data_b     <= '0;
      data_slot  <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_nx;
      data_valid <= 1'b0;
      sweep_done <= 1'b0;
      if ((state_nx != state) || (state == IDLE))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (start_sweep)
        aux_q <= aux_cmd;

      if (state == IDLE) begin
        supp <= 2'd2;
        slot <= '0;
      end

      if (gap_end)
        slot <= last_slot ? 7'd0 : (slot + 7'd1);

      // Word A bits land on edges ending c=4..64, word B on edges ending c=6..66.
      if (state == FRAME) begin
        if ((cnt >= CW'(4)) && (cnt <= CW'(64)) && (cnt[1:0] == 2'b00))
          sh_a <= {sh_a[14:0], MISO};
        if ((cnt >= CW'(6)) && (cnt <= CW'(66)) && (cnt[1:0] == 2'b10))
          sh_b <= {sh_b[14:0], MISO};
      end

      if (frame_end) begin
        sweep_done <= last_slot;
        if (supp != 2'd0) begin
          supp <= supp - 2'd1;
        end else begin
          data_valid <= 1'b1;
          data_a     <= sh_a;
          data_b     <= sh_b;
          data_slot  <= tag[5:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_rhd_spi_sequencer.sv
// Directed bench for rhd_spi_sequencer: a behavioural headstage returns fixed DDR words,
// a monitor logs MOSI commands, frame lengths, results and sweep_done times.
module tb_rhd_spi_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [47:0] aux_cmd;
  logic        CS, SCLK, MOSI;
  logic        MISO = 1'b0;
  logic        data_valid;
  logic [15:0] data_a, data_b;
  logic [5:0]  data_slot;
  logic        sweep_done, busy;

  rhd_spi_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .aux_cmd(aux_cmd),
    .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .data_valid(data_valid), .data_a(data_a), .data_b(data_b),
    .data_slot(data_slot), .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  slot;
    int          frame;
  } vrec_t;

  logic [15:0] exp_q[$];
  logic [15:0] cmd_log[$];
  int          len_log[$];
  vrec_t       vlog[$];
  int          sd_cyc[$];
  int          cyc = 0;
  int          first_cs = -1;
  int          mc = -1;
  logic        prev_cs = 1'b1;
  logic [15:0] cur = '0;
  int          sclk_bad = 0;
  logic [15:0] pat_a = 16'h1234;
  logic [15:0] pat_b = 16'h1254;
  int          compared = 0;
  int          mism = 0;

  always @(posedge clk) cyc++;

  // Monitor plus headstage model; frame cycle mc is 0 in the first CS-low cycle.
  always @(negedge clk) begin
    logic sclk_exp;
    if (CS && !prev_cs) begin
      cmd_log.push_back(cur);
      len_log.push_back(mc + 1);
      cur = '0;
    end
    if (data_valid) vlog.push_back('{data_a, data_b, data_slot, cmd_log.size() - 1});
    if (sweep_done) sd_cyc.push_back(cyc);
    if (!CS) begin
      mc = prev_cs ? 0 : mc + 1;
      if (first_cs < 0) first_cs = cyc;
    end else begin
      mc = -1;
    end
    prev_cs = CS;
    sclk_exp = !CS && (mc < 64) && ((mc % 4) >= 2);
    if (SCLK !== sclk_exp) sclk_bad++;
    if (!CS && (mc < 64) && ((mc % 4) == 1)) cur = {cur[14:0], MOSI};
    if (!CS && (mc >= 4) && (mc <= 64) && ((mc % 4) == 0))
      MISO = pat_a[15 - (mc - 4) / 4];
    else if (!CS && (mc >= 6) && (mc <= 66) && ((mc % 4) == 2))
      MISO = pat_b[15 - (mc - 6) / 4];
    else
      MISO = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout(input string tag);
    compared++;
    mism++;
    $display("FAIL %s: wait bound expired at cycle %0d", tag, cyc);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while ((cmd_log.size() < n) && (t < budget)) begin step(); t++; end
    if (cmd_log.size() < n) timeout("wait_frames");
  endtask

  task automatic wait_sd(input int n, input int budget);
    int t = 0;
    while ((sd_cyc.size() < n) && (t < budget)) begin step(); t++; end
    if (sd_cyc.size() < n) timeout("wait_sweep_done");
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && (t < budget)) begin step(); t++; end
    if (busy) timeout("wait_idle");
  endtask

  task automatic wait_c30(input int budget);
    int t = 0;
    while (!(!CS && (mc == 30)) && (t < budget)) begin step(); t++; end
    if (!(!CS && (mc == 30))) timeout("wait_c30");
  endtask

  initial begin
    int bad;
    int vbefore;
    int base;
    reset   = 1'b1;
    enable  = 1'b0;
    aux_cmd = '0;
    repeat (3) step();
    chk("rst_cs", CS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_data_b", data_b, 0);
    chk("rst_slot", data_slot, 0);
    reset = 1'b0;

    // Sweep 1
    aux_cmd = 48'hE800_D000_C000;
    enable  = 1'b1;
    wait_sd(1, 3000);
    // Last frame (slot 34) ends 34*76+68 cycles after the first CS-low cycle.
    if (sd_cyc.size() >= 1) chk("sweep_done_time", sd_cyc[0] - first_cs, 2652);
    exp_q = '{16'h0000, 16'h0500, 16'h1F00, 16'hE800, 16'hD000, 16'hC000};
    if (cmd_log.size() >= 35) begin
      chk("cmd_f0", cmd_log[0], exp_q[0]);
      chk("cmd_f5", cmd_log[5], exp_q[1]);
      chk("cmd_f31", cmd_log[31], exp_q[2]);
      chk("cmd_aux0", cmd_log[32], exp_q[3]);
      chk("cmd_aux1", cmd_log[33], exp_q[4]);
      chk("cmd_aux2", cmd_log[34], exp_q[5]);
    end else timeout("sweep1_frames");
    chk("sweep1_sd_count", sd_cyc.size(), 1);
    chk("sweep1_valids", vlog.size(), 33);
    if (vlog.size() > 0) begin
      chk("first_valid_frame", vlog[0].frame, 2);
      chk("first_valid_slot", vlog[0].slot, 0);
      chk("first_data_a", vlog[0].a, 16'h1234);
      chk("first_data_b", vlog[0].b, 16'h1254);
    end
    bad = 0;
    foreach (len_log[i]) if (len_log[i] != 68) bad++;
    chk("frame_len_bad", bad, 0);

    // Sweep 2: aux changed mid-sweep must not affect this sweep.
    wait_frames(45, 1000);
    aux_cmd = 48'h0;
    wait_sd(2, 3000);
    if (sd_cyc.size() >= 2) chk("sweep_period", sd_cyc[1] - sd_cyc[0], 2660);
    if (cmd_log.size() >= 70) begin
      chk("s2_aux0_old", cmd_log[67], 16'hE800);
      chk("s2_aux1_old", cmd_log[68], 16'hD000);
      chk("s2_aux2_old", cmd_log[69], 16'hC000);
    end else timeout("sweep2_frames");
    chk("sweep2_valids", vlog.size(), 68);
    if (vlog.size() >= 37) begin
      chk("wrap_slot33", vlog[33].slot, 33);
      chk("wrap_slot34", vlog[34].slot, 34);
      chk("wrap_slot0", vlog[35].slot, 0);
      chk("wrap_slot1", vlog[36].slot, 1);
    end
    bad = 0;
    foreach (vlog[i]) begin
      if (vlog[i].slot != 6'(i % 35)) bad++;
      if ((vlog[i].a != 16'h1234) || (vlog[i].b != 16'h1254)) bad++;
    end
    chk("slot_data_seq_bad", bad, 0);

    // Sweep 3: enable dropped around slot 10, sweep still completes.
    wait_frames(80, 1000);
    enable = 1'b0;
    wait_idle(3000);
    chk("drop_frames", cmd_log.size(), 105);
    chk("drop_valids", vlog.size(), 103);
    chk("drop_busy", busy, 0);
    chk("drop_cs", CS, 1);
    if (cmd_log.size() >= 105) begin
      chk("s3_aux0_new", cmd_log[102], 16'h0000);
      chk("s3_aux1_new", cmd_log[103], 16'h0000);
      chk("s3_aux2_new", cmd_log[104], 16'h0000);
    end
    repeat (20) step();
    chk("idle_stays", cmd_log.size(), 105);

    // Re-enable: first two results suppressed again.
    enable = 1'b1;
    wait_frames(108, 400);
    chk("reen_valids", vlog.size(), 104);
    if (vlog.size() >= 104) begin
      chk("reen_frame", vlog[103].frame, 107);
      chk("reen_slot", vlog[103].slot, 0);
    end

    // Reset during c=30 of slot 7.
    wait_frames(112, 600);
    wait_c30(200);
    vbefore = vlog.size();
    chk("pre_reset_valids", vbefore, 108);
    reset = 1'b1;
    step();
    chk("mr_cs", CS, 1);
    chk("mr_sclk", SCLK, 0);
    chk("mr_mosi", MOSI, 0);
    chk("mr_busy", busy, 0);
    chk("mr_valid", data_valid, 0);
    chk("mr_data_a", data_a, 0);
    chk("mr_data_b", data_b, 0);
    chk("mr_slot", data_slot, 0);
    reset = 1'b0;
    base = cmd_log.size();
    chk("mr_partial_len", len_log[len_log.size() - 1], 31);
    wait_frames(base + 3, 400);
    chk("mr_valids", vlog.size(), vbefore + 1);
    if (cmd_log.size() >= base + 3) begin
      chk("mr_cmd_slot0", cmd_log[base], 16'h0000);
      chk("mr_cmd_slot1", cmd_log[base + 1], 16'h0100);
    end
    if (vlog.size() == vbefore + 1) begin
      chk("mr_first_frame", vlog[vbefore].frame, base + 2);
      chk("mr_first_slot", vlog[vbefore].slot, 0);
    end
    chk("sclk_bad", sclk_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
